// File: rtl/audio_gen_pkg.sv
// audio_gen_pkg: shared mode encoding, NCO increment helper and overrun counter width
package audio_gen_pkg;
  typedef enum logic [1:0] {
    MODE_SILENCE = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_SQUARE  = 2'd2
  } mode_t;
  localparam int OVR_W = 16;
  function automatic longint unsigned nco_inc(longint unsigned clk_hz, longint unsigned rate, int unsigned acc_width);
    return ((rate << acc_width) + clk_hz / 2) / clk_hz;
  endfunction
endpackage

// File: rtl/audio_nco.sv
// audio_nco: phase accumulator emitting a registered one-cycle carry strobe per wrap
module audio_nco #(
  parameter int ACC_WIDTH = 32,
  parameter logic [ACC_WIDTH-1:0] INC = 1
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic enable,
  output logic sample_tick
);
  logic [ACC_WIDTH-1:0] acc;
  always_ff @(posedge clk_pixel or posedge reset)
    if (reset) begin
      acc <= '0;
      sample_tick <= 1'b0;
    end else if (enable) begin
      {sample_tick, acc} <= {1'b0, acc} + {1'b0, INC};
    end else begin
      acc <= '0;
      sample_tick <= 1'b0;
    end
endmodule

// File: rtl/audio_sample_gen.sv
// audio_sample_gen: NCO-paced multi-channel test sample source with valid/ready output and overrun count
module audio_sample_gen
  import audio_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ = 74250000,
  parameter int unsigned AUDIO_RATE = 48000,
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int ACC_WIDTH = 32,
  parameter int SQUARE_PERIOD = 48
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic enable,
  input  logic [1:0] mode,
  input  logic [AUDIO_BIT_WIDTH-1:0] step,
  output logic sample_tick,
  output logic [NUM_CHANNELS-1:0][AUDIO_BIT_WIDTH-1:0] sample_word,
  output logic sample_valid,
  input  logic sample_ready,
  output logic [OVR_W-1:0] overrun_count
);
  localparam int W = AUDIO_BIT_WIDTH;
  localparam int N = NUM_CHANNELS;
  localparam int SQ_W = SQUARE_PERIOD > 2 ? $clog2(SQUARE_PERIOD) : 1;
  localparam logic [ACC_WIDTH-1:0] INC = ACC_WIDTH'(nco_inc(CLK_HZ, AUDIO_RATE, ACC_WIDTH));
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQUARE_PERIOD - 1);
  localparam logic [SQ_W-1:0] SQ_HALF = SQ_W'(SQUARE_PERIOD / 2);
  logic [1:0] mode_q;
  logic mode_chg;
  logic [N-1:0][W-1:0] ramp_q, ramp_eff, ramp_nxt, gen_word;
  logic [SQ_W-1:0] sq_q, sq_eff, sq_nxt;
  audio_nco #(.ACC_WIDTH(ACC_WIDTH), .INC(INC)) u_nco (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .enable(enable),
    .sample_tick(sample_tick)
  );
  always_comb begin
    mode_chg = mode != mode_q;
    ramp_eff = mode_chg ? '0 : ramp_q;
    sq_eff = mode_chg ? '0 : sq_q;
    sq_nxt = sq_eff == SQ_LAST ? '0 : sq_eff + 1'b1;
    ramp_nxt = '0;
    gen_word = '0;
    for (int k = 0; k < N; k++) begin
      ramp_nxt[k] = k[0] ? ramp_eff[k] - step : ramp_eff[k] + step;
      gen_word[k] = mode == MODE_RAMP ? ramp_nxt[k] :
                    mode == MODE_SQUARE ? (sq_eff < SQ_HALF ? step : -step) : '0;
    end
  end
  always_ff @(posedge clk_pixel or posedge reset)
    if (reset) begin
      mode_q <= MODE_SILENCE;
      ramp_q <= '0;
      sq_q <= '0;
      sample_word <= '0;
      sample_valid <= 1'b0;
      overrun_count <= '0;
    end else begin
      mode_q <= mode;
      ramp_q <= sample_tick ? (mode == MODE_RAMP ? ramp_nxt : '0) : ramp_eff;
      sq_q <= sample_tick ? (mode == MODE_SQUARE ? sq_nxt : '0) : sq_eff;
      if (sample_tick && sample_valid && !sample_ready) begin
        if (overrun_count != '1) overrun_count <= overrun_count + 1'b1;
      end else if (sample_tick) begin
        sample_word <= gen_word;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_audio_sample_gen.sv
// tb_audio_sample_gen: directed table-driven bench for audio_sample_gen
module tb_audio_sample_gen;
  logic clk_pixel, reset, enable, sample_ready, sample_tick, sample_valid;
  logic [1:0] mode;
  logic [15:0] step, overrun_count;
  logic [1:0][15:0] sample_word;
  int total, bad;
  typedef struct {
    logic [1:0] mode;
    logic [15:0] step;
    logic [15:0] ch0;
    logic [15:0] ch1;
  } vec_t;
  vec_t tbl[9];
  audio_sample_gen #(
    .CLK_HZ(1000), .AUDIO_RATE(48), .AUDIO_BIT_WIDTH(16),
    .NUM_CHANNELS(2), .ACC_WIDTH(32), .SQUARE_PERIOD(4)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .step(step),
    .sample_tick(sample_tick),
    .sample_word(sample_word),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun_count(overrun_count)
  );
  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_pixel);
    #1;
  endtask
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!sample_tick && n < 64);
    if (!sample_tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    int ticks, first, width_bad;
    logic prev;
    tbl[0] = '{2'd1, 16'h1111, 16'h1111, 16'hEEEF};
    tbl[1] = '{2'd1, 16'h1111, 16'h2222, 16'hDDDE};
    tbl[2] = '{2'd1, 16'h1111, 16'h3333, 16'hCCCD};
    tbl[3] = '{2'd2, 16'h0100, 16'h0100, 16'h0100};
    tbl[4] = '{2'd2, 16'h0100, 16'h0100, 16'h0100};
    tbl[5] = '{2'd2, 16'h0100, 16'hFF00, 16'hFF00};
    tbl[6] = '{2'd2, 16'h0100, 16'hFF00, 16'hFF00};
    tbl[7] = '{2'd2, 16'h0100, 16'h0100, 16'h0100};
    tbl[8] = '{2'd3, 16'h0100, 16'h0000, 16'h0000};
    total = 0;
    bad = 0;
    reset = 1'b1;
    enable = 1'b1;
    mode = 2'd0;
    step = 16'h0;
    sample_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_tick", 32'(sample_tick), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_word", 32'(sample_word), 32'd0);
    chk("rst_ovr", 32'(overrun_count), 32'd0);
    reset = 1'b0;
    ticks = 0;
    first = 0;
    width_bad = 0;
    prev = 1'b0;
    for (int k = 1; k <= 10001; k++) begin
      cyc();
      if (sample_tick) begin
        if (k <= 10000) ticks++;
        if (first == 0) first = k;
        if (prev) width_bad = 1;
      end
      prev = sample_tick;
    end
    chk("nco_ticks_10000", 32'(ticks), 32'd479);
    chk("nco_tick_10001", 32'(sample_tick), 32'd1);
    chk("nco_first_tick", 32'(first), 32'd21);
    chk("nco_tick_width", 32'(width_bad), 32'd0);
    cyc();
    cyc();
    chk("silence_word", 32'(sample_word), 32'd0);
    for (int i = 0; i < 9; i++) begin
      mode = tbl[i].mode;
      step = tbl[i].step;
      wait_tick();
      chk($sformatf("v%0d_valid_at_tick", i), 32'(sample_valid), 32'd0);
      cyc();
      chk($sformatf("v%0d_valid", i), 32'(sample_valid), 32'd1);
      chk($sformatf("v%0d_ch0", i), 32'(sample_word[0]), 32'(tbl[i].ch0));
      chk($sformatf("v%0d_ch1", i), 32'(sample_word[1]), 32'(tbl[i].ch1));
    end
    cyc();
    mode = 2'd1;
    step = 16'h1111;
    sample_ready = 1'b0;
    wait_tick();
    cyc();
    wait_tick();
    wait_tick();
    cyc();
    chk("ovr_count", 32'(overrun_count), 32'd2);
    chk("ovr_hold_ch0", 32'(sample_word[0]), 32'h1111);
    chk("ovr_hold_ch1", 32'(sample_word[1]), 32'hEEEF);
    sample_ready = 1'b1;
    cyc();
    chk("ovr_accept_valid", 32'(sample_valid), 32'd0);
    wait_tick();
    cyc();
    chk("ovr_next_ch0", 32'(sample_word[0]), 32'h4444);
    chk("ovr_next_ch1", 32'(sample_word[1]), 32'hBBBC);
    chk("ovr_count_kept", 32'(overrun_count), 32'd2);
    cyc();
    sample_ready = 1'b0;
    wait_tick();
    cyc();
    chk("sim_pre_ch0", 32'(sample_word[0]), 32'h5555);
    wait_tick();
    sample_ready = 1'b1;
    cyc();
    chk("sim_valid", 32'(sample_valid), 32'd1);
    chk("sim_ch0", 32'(sample_word[0]), 32'h6666);
    chk("sim_ch1", 32'(sample_word[1]), 32'h999A);
    chk("sim_ovr", 32'(overrun_count), 32'd2);
    cyc();
    sample_ready = 1'b0;
    wait_tick();
    cyc();
    force dut.overrun_count = 16'hFFFF;
    cyc();
    release dut.overrun_count;
    wait_tick();
    cyc();
    chk("sat_ovr", 32'(overrun_count), 32'hFFFF);
    chk("sat_hold_ch0", 32'(sample_word[0]), 32'h7777);
    chk("mid_valid_before", 32'(sample_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    chk("mid_rst_word", 32'(sample_word), 32'd0);
    chk("mid_rst_ovr", 32'(overrun_count), 32'd0);
    chk("mid_rst_tick", 32'(sample_tick), 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    first = 0;
    for (int k = 1; k <= 64 && first == 0; k++) begin
      cyc();
      if (sample_tick) first = k;
    end
    chk("post_rst_first_tick", 32'(first), 32'd21);
    cyc();
    chk("post_rst_ch0", 32'(sample_word[0]), 32'h1111);
    chk("post_rst_ch1", 32'(sample_word[1]), 32'hEEEF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_sample_gen.md
Name: audio_sample_gen

Overview:
Parametrised successor to the fixed clk_pixel divider and two-channel ramp audio source. It replaces the derived audio clock with a fractional phase accumulator (NCO) that produces an exact-average sample-rate strobe in the clk_pixel domain. It generates NUM_CHANNELS test samples in a selectable mode and presents them through a valid/ready handshake to the HDMI audio packetiser, with overrun detection.

Parameters:
CLK_HZ, 74250000, clk_pixel frequency in Hz
AUDIO_RATE, 48000, sample rate in Hz
AUDIO_BIT_WIDTH, 16, sample word width W
NUM_CHANNELS, 2, channel count N (1..8)
ACC_WIDTH, 32, NCO accumulator width
SQUARE_PERIOD, 48, square-wave period in samples (even, >=2)

Ports:
clk_pixel  input  1  sole clock
reset  input  1  asynchronous, active-high
enable  input  1  1 = run NCO and generator
mode  input  2  0 silence, 1 ramp, 2 square, 3 treated as silence
step  input  W  ramp increment / square amplitude
sample_tick  output  1  one-cycle strobe per sample period
sample_word  output  N x W  per-channel samples, two's complement
sample_valid  output  1  sample_word holds an unconsumed sample
sample_ready  input  1  consumer accepts when valid && ready
overrun_count  output  16  saturating count of dropped samples

Behaviour:
- Reset values: NCO acc 0; sample_tick 0; sample_word all 0; sample_valid 0; overrun_count 0; ramp and square state 0.
- NCO: INC = round(AUDIO_RATE * 2^ACC_WIDTH / CLK_HZ), elaboration-time constant. Each cycle with enable=1: acc <= acc + INC (mod 2^ACC_WIDTH). sample_tick is the registered carry-out, high on the cycle after the wrap.
- enable=0: acc cleared to 0, no ticks. A pending sample_valid is held until accepted.
- On a sample_tick cycle, new samples are computed and registered. sample_valid rises on the next cycle, giving one cycle of latency from tick.
- Ramp: channel k state s_k. Even k: s_k += step; odd k: s_k -= step, mod 2^W. Output is the updated s_k.
- Square: tick counter 0..SQUARE_PERIOD-1, wraps. Output is +step while the counter < SQUARE_PERIOD/2, else -step (two's complement), same on all channels. The first tick after entering square outputs +step.
- Silence: outputs 0.
- A change of mode clears ramp and square state. The new mode applies from the next tick.
- Handshake: sample_word is stable while sample_valid && !sample_ready. valid drops on acceptance unless a new sample is loaded in the same cycle.
- Tick while valid && !ready: the new sample is dropped, the old word is held, and overrun_count increments, saturating at 0xFFFF. Generator state (ramp and square) still advances.
- Tick in the same cycle as acceptance: the new sample loads, valid stays 1, no overrun.
- Reset asserted mid-operation: all state returns to reset values immediately. There are no ticks until INC accumulates a carry after release.

Decomposition:
- Package audio_gen_pkg:
  - mode enum (MODE_SILENCE, MODE_RAMP, MODE_SQUARE)
  - function nco_inc(clk_hz, rate, acc_width) returning INC
  - OVR_W = 16
- Sub-module audio_nco, parametrised on ACC_WIDTH and INC, with ports clk_pixel, reset, enable, sample_tick. The generator, handshake register and overrun counter stay in audio_sample_gen.

Test Plan:
- NCO accuracy: CLK_HZ=1000, AUDIO_RATE=48, INC=206158430, enable=1 from reset release -> exactly 479 ticks in the first 10000 cycles, the 480th at cycle 10001, tick width always 1 cycle.
- Ramp, N=2, step=0x1111, ready=1 -> accepted words after ticks 1,2,3: ch0 0x1111/0x2222/0x3333, ch1 0xEEEF/0xDDDE/0xCCCD. valid rises 1 cycle after each tick.
- Overrun: ramp, ready=0 across 3 ticks, then ready=1 -> sample_word stays 0x1111/0xEEEF, overrun_count=2. The next accepted word is 0x4444/0xBBBC.
- Square: SQUARE_PERIOD=4, step=0x0100, ready=1 -> sequence 0x0100, 0x0100, 0xFF00, 0xFF00, 0x0100. Mode 3 gives 0x0000.
- Simultaneous tick and acceptance in the same cycle -> valid stays 1, new word loaded, overrun_count unchanged. A forced 0xFFFF overrun_count stays saturated on a further overrun.
- Reset mid-stream while valid=1 -> valid=0, words=0, count=0 asynchronously. The first post-release tick is at the NCO first-carry cycle (ceil(2^ACC_WIDTH / INC)).
